// File: rtl/uart_burst_pacer_if.sv
// Handshake bundle between the burst pacer, the SDRAM read FIFO and the UART transmitter.
// master = pacer side, slave = SDRAM FIFO / UART side.
interface uart_burst_pacer_if #(
    parameter int DW = 8,
    parameter int CW = 10
);
    logic [CW-1:0] sdram_rd_fifo_cnt;
    logic [DW-1:0] sdram_rd_data;
    logic          sdram_fifo_rd_en;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_flag;

    modport master (
        input  sdram_rd_fifo_cnt, sdram_rd_data, tx_ready,
        output sdram_fifo_rd_en, tx_data, tx_flag
    );

    modport slave (
        output sdram_rd_fifo_cnt, sdram_rd_data, tx_ready,
        input  sdram_fifo_rd_en, tx_data, tx_flag
    );
endinterface

// File: rtl/uart_burst_pacer.sv
// Fetches bursts from the SDRAM read FIFO into a local FIFO and releases one word per UART frame.
// Optional macro UART_BURST_PREFETCH_EN: fetch the next burst while the previous one drains.
module uart_burst_pacer #(
    parameter int DW         = 8,
    parameter int CW         = 10,
    parameter int BAUD_DIV   = 5208,
    parameter int FRAME_BITS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] burst_len,
    output logic [CW-1:0] local_cnt,
    output logic          busy,
    uart_burst_pacer_if.master bus
);
    localparam int FRAME_CYC = BAUD_DIV * FRAME_BITS;
    localparam int TW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYC - 1);
    localparam logic [CW-1:0] FIFO_MAX   = {CW{1'b1}};
    localparam int DEPTH = 2 ** CW;

    typedef enum logic [1:0] {IDLE, FETCH, SETTLE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] phase_cnt;
    logic          rd_en_p0;
    logic          vld_p1;
    logic [CW-1:0] wptr, rptr;
    logic [TW-1:0] timer;
    logic          rd_issue_p0;
    logic          fetch_gate;
    logic          start;
    logic [DW-1:0] mem [DEPTH];

`ifdef UART_BURST_PREFETCH_EN
    assign fetch_gate = (FIFO_MAX - local_cnt) >= burst_len;
`else
    // Wait until the local FIFO is empty and nothing is still in the write or read pipe.
    assign fetch_gate = (local_cnt == '0) && !vld_p1 && !bus.tx_flag;
`endif

    assign start = enable && (burst_len != '0) &&
                   (bus.sdram_rd_fifo_cnt >= burst_len) && fetch_gate;

    // A read in the previous cycle shows up as tx_flag high in this one.
    assign rd_issue_p0 = (local_cnt != '0) && (timer == '0) && bus.tx_ready && !bus.tx_flag;

    assign bus.sdram_fifo_rd_en = rd_en_p0;
    assign busy = (state != IDLE) || (local_cnt != '0);

    always_comb begin
        state_nxt = state;
        rd_en_p0  = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH: begin
                rd_en_p0 = 1'b1;
                if (phase_cnt == CW'(1)) state_nxt = SETTLE;
            end
            SETTLE:  if (phase_cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // burst_len is CW bits wide, so it can never exceed the usable FIFO depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE:    if (start) phase_cnt <= burst_len;
                FETCH:   phase_cnt <= (phase_cnt == CW'(1)) ? CW'(2) : phase_cnt - CW'(1);
                SETTLE:  phase_cnt <= phase_cnt - CW'(1);
                default: phase_cnt <= '0;
            endcase
        end
    end

    // Stage p1: SDRAM read data arrives one cycle after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            wptr   <= '0;
        end else begin
            vld_p1 <= rd_en_p0;
            if (vld_p1) wptr <= wptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) mem[wptr] <= bus.sdram_rd_data;
    end

    // Timer loads on the edge that raises tx_flag so frames start exactly FRAME_CYC apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr        <= '0;
            timer       <= '0;
            bus.tx_flag <= 1'b0;
            bus.tx_data <= '0;
        end else begin
            bus.tx_flag <= rd_issue_p0;
            if (rd_issue_p0) begin
                rptr        <= rptr + CW'(1);
                bus.tx_data <= mem[rptr];
                timer       <= TIMER_LOAD;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            local_cnt <= '0;
        end else begin
            unique case ({vld_p1, rd_issue_p0})
                2'b10:   local_cnt <= local_cnt + CW'(1);
                2'b01:   local_cnt <= local_cnt - CW'(1);
                default: local_cnt <= local_cnt;
            endcase
        end
    end
endmodule

// File: doc/uart_burst_pacer.md
Name: uart_burst_pacer

Overview:
Parametrised bridge between the SDRAM interface read FIFO and the UART transmitter.
- Fetches bursts of burst_len words from the SDRAM read FIFO into an internal local FIFO (inferred RAM, no vendor IP).
- Releases stored words one per UART frame, paced by an internal frame timer and the transmitter's ready handshake.
- Sits between the SDRAM controller's read port and the uart_tx module.

Parameters:
DW, 8, data width of SDRAM read data and tx_data
CW, 10, width of count ports; local FIFO depth = 2**CW - 1 words max usable
BAUD_DIV, 5208, clock cycles per UART bit
FRAME_BITS, 10, bits per UART frame (start + data + stop)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
enable  in  1  allow new bursts to start; high = run
burst_len  in  CW  words per burst; sampled at fetch start
sdram_rd_fifo_cnt  in  CW  word count of SDRAM read FIFO
sdram_rd_data  in  DW  SDRAM read FIFO data, valid 1 cycle after sdram_fifo_rd_en
sdram_fifo_rd_en  out  1  SDRAM read FIFO read request
tx_ready  in  1  UART transmitter idle and able to accept a byte
tx_data  out  DW  byte to UART, valid while tx_flag high
tx_flag  out  1  one-cycle strobe: tx_data valid, start frame
local_cnt  out  CW  local FIFO occupancy
busy  out  1  high whenever state != IDLE or local_cnt != 0

Behaviour:
- Reset values: sdram_fifo_rd_en=0, tx_flag=0, tx_data=0, local_cnt=0, busy=0, frame timer=0, state=IDLE.
- Fetch FSM states: IDLE, FETCH, SETTLE.
- IDLE -> FETCH when all of:
  - enable=1
  - burst_len != 0
  - sdram_rd_fifo_cnt >= burst_len
  - fetch gate open (see Optional Feature)
  - On entry, latch blen = min(burst_len, 2**CW-1).
- FETCH:
  - sdram_fifo_rd_en=1 for exactly blen consecutive cycles.
  - Local FIFO write = sdram_fifo_rd_en delayed 1 cycle; data = sdram_rd_data.
  - Then -> SETTLE.
- SETTLE: 2 cycles with rd_en=0, covering upstream count update latency; then -> IDLE.
- enable deasserted during FETCH: burst still completes in full. Truncation is forbidden.
- burst_len changes mid-burst are ignored (latched value is used).
- Drain:
  - Frame timer loads BAUD_DIV*FRAME_BITS-1 on each tx_flag, then counts down to 0.
  - Local FIFO read issued when local_cnt != 0, timer == 0, tx_ready=1, and no read issued in the previous cycle.
  - Read latency 1: tx_flag pulses the cycle after the read, with tx_data from the FIFO.
  - Drain runs independently of enable.
- local_cnt = writes - reads (saturating logic not needed; FIFO never overflows by construction).
  - Simultaneous write and read: count unchanged.
  - A read at empty is never issued.
  - A write at full is never issued, guaranteed by the fetch gate.
- Minimum tx_flag spacing: BAUD_DIV*FRAME_BITS cycles. Longer if tx_ready is low.
- Async reset mid-burst: all state cleared, local data discarded. The upstream FIFO keeps any unread words.

Optional Feature:
Macro: UART_BURST_PREFETCH_EN
- Defined: fetch gate = (2**CW-1 - local_cnt) >= burst_len. The next burst is fetched while the previous one drains (double buffering).
- Undefined: fetch gate = (local_cnt == 0 and no read/tx_flag in flight). A burst starts only when the local FIFO is fully drained, giving strictly alternating fetch/drain.

Test Plan:
1. BAUD_DIV=4, FRAME_BITS=10, burst_len=8, sdram_rd_fifo_cnt=8, data 0x10..0x17, tx_ready=1 -> rd_en high exactly 8 cycles; 8 tx_flag pulses 40 cycles apart carrying 0x10..0x17 in order; busy falls after the last byte.
2. sdram_rd_fifo_cnt=7, burst_len=8 -> no rd_en. Raise count to 8 -> fetch starts within 1 cycle.
3. tx_ready held low for 100 cycles after the first byte -> second tx_flag delayed until tx_ready=1. No byte lost or duplicated.
4. Deassert enable mid-FETCH (cycle 3 of 8) -> all 8 words still fetched and sent; no further burst although the count stays >= 8.
5. Assert rst_n low mid-drain after byte 3 -> outputs return to reset values next clock edge. After release with count 8, a fresh burst of 8 is sent from the first word.
6. Prefetch: 20 words available, burst_len=8, CW=5 -> with UART_BURST_PREFETCH_EN, the second burst is fetched before the first drains. Without the macro, the second burst starts only after local_cnt reaches 0. Output order is 0..15 in both cases.
